// File: rtl/sim_ctrl_pkg.sv
// Shared types, default run limits and the popcount helper for the simulation run controller.
`timescale 1ns/1ps
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    HANG  = 3'd4
  } run_state_t;

  localparam int DEF_CYCLE_W      = 32;
  localparam int DEF_MAX_CYCLES   = 100000;
  localparam int DEF_HANG_CYCLES  = 1000;
  localparam int DEF_DRAIN_CYCLES = 16;
  localparam int DEF_NUM_SRC      = 2;

  // Widest progress vector popcount() accepts; callers zero-extend into it.
  localparam int POP_MAX_W = 64;

  function automatic logic [7:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX_W; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/sim_run_ctrl_sat_accum.sv
// Saturating accumulator: adds a zero-extended increment each enabled edge and sticks at all-ones.
`timescale 1ns/1ps
module sat_accum #(
  parameter int W    = 32,
  parameter int IN_W = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [IN_W-1:0] inc_i,
  output logic [W-1:0]    acc_o
);

  logic [W-1:0] acc_q, acc_d;
  logic [W:0]   sum;

  // One extra bit holds the carry-out that triggers saturation.
  always_comb begin
    sum   = {1'b0, acc_q} + (W+1)'(inc_i);
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = sum[W] ? '1 : sum[W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: cycle/retire counting, end-of-test drain, timeout and hang watchdog.
// Optional SIM_RUN_CTRL_FINISH_EN: report the verdict and end the simulation from inside the block.
`timescale 1ns/1ps
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int CYCLE_W      = DEF_CYCLE_W,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int HANG_CYCLES  = DEF_HANG_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int NUM_SRC      = DEF_NUM_SRC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] progress_vld,
  input  logic               eot_req,
  input  logic               eot_pass,
  output logic [2:0]         run_state,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [CYCLE_W-1:0] retire_total,
  output logic               sim_done,
  output logic               sim_pass,
  output logic               hang_detect
);

  localparam int POP_W  = $clog2(NUM_SRC + 1);
  localparam int IDLE_W = $clog2(HANG_CYCLES + 1);
  localparam int DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  run_state_t        state_q, state_d;
  logic              pass_q, pass_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic              done_q, spass_q, hang_q;

  logic [POP_W-1:0]  pop;
  logic [IDLE_W-1:0] idle_cnt;
  logic              any_prog, in_run, in_act, timeout, hang_hit;

  assign pop      = POP_W'(popcount(POP_MAX_W'(progress_vld)));
  assign any_prog = |progress_vld;
  assign in_run   = (state_q == RUN);
  assign in_act   = (state_q == RUN) || (state_q == DRAIN);

  sat_accum #(.W(CYCLE_W), .IN_W(1)) u_cyc (
    .clk_i (clk), .rst_i (reset), .clr_i (1'b0), .en_i (in_act),
    .inc_i (1'b1), .acc_o (cycle_count)
  );

  sat_accum #(.W(CYCLE_W), .IN_W(POP_W)) u_ret (
    .clk_i (clk), .rst_i (reset), .clr_i (1'b0), .en_i (in_act),
    .inc_i (pop), .acc_o (retire_total)
  );

  sat_accum #(.W(IDLE_W), .IN_W(1)) u_idle (
    .clk_i (clk), .rst_i (reset), .clr_i (in_run & any_prog), .en_i (in_run),
    .inc_i (1'b1), .acc_o (idle_cnt)
  );

  // Limits compared at 64 bits so a narrow saturated counter never aliases a large limit.
  assign timeout  = (64'(cycle_count) == 64'(MAX_CYCLES - 1));
  assign hang_hit = (64'(idle_cnt) == 64'(HANG_CYCLES - 1)) && !any_prog;

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    drn_d   = drn_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (eot_req) begin
          pass_d  = eot_pass;
          drn_d   = '0;
          state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        end else if (timeout) begin
          pass_d  = 1'b0;
          state_d = DONE;
        end else if (hang_hit) begin
          state_d = HANG;
        end
      end
      DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drn_q == DRN_LAST) state_d = DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pass_q  <= 1'b0;
      drn_q   <= '0;
      done_q  <= 1'b0;
      spass_q <= 1'b0;
      hang_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      drn_q   <= drn_d;
      done_q  <= (state_d == DONE) || (state_d == HANG);
      spass_q <= (state_d == DONE) && pass_d;
      hang_q  <= (state_d == HANG);
    end
  end

  assign run_state   = state_q;
  assign sim_done    = done_q;
  assign sim_pass    = spass_q;
  assign hang_detect = hang_q;

`ifdef SIM_RUN_CTRL_FINISH_EN
`ifndef DEBUG
`define DEBUG(msg) $display msg
`endif
  logic fin_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fin_q <= 1'b0;
    end else begin
      if (!fin_q && (state_q != DONE) && (state_q != HANG) &&
          ((state_d == DONE) || (state_d == HANG))) begin
        `DEBUG(("sim_run_ctrl: %s cycles=%0d retired=%0d",
                state_d.name(), cycle_count, retire_total));
        fin_q <= 1'b1;
      end
      if (fin_q) $finish();
    end
  end
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: several parameterisations run side by side on one clock.
`timescale 1ns/1ps
module tb_sim_run_ctrl;
  import sim_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  pv [1:5];
  logic [3:0]  pv4;
  logic        eot [1:5];
  logic        ep  [1:5];
  logic [2:0]  st  [1:5];
  logic [31:0] cc  [1:4];
  logic [31:0] rt  [1:4];
  logic [3:0]  cc5, rt5;
  logic        dn  [1:5];
  logic        ps  [1:5];
  logic        hg  [1:5];

  int n_cmp = 0;
  int n_err = 0;

  // u1: defaults (eot/drain, reset cases)
  sim_run_ctrl u1 (
    .clk(clk), .reset(rst), .progress_vld(pv[1]), .eot_req(eot[1]), .eot_pass(ep[1]),
    .run_state(st[1]), .cycle_count(cc[1]), .retire_total(rt[1]),
    .sim_done(dn[1]), .sim_pass(ps[1]), .hang_detect(hg[1]));

  // u2: timeout
  sim_run_ctrl #(.MAX_CYCLES(100)) u2 (
    .clk(clk), .reset(rst), .progress_vld(pv[2]), .eot_req(eot[2]), .eot_pass(ep[2]),
    .run_state(st[2]), .cycle_count(cc[2]), .retire_total(rt[2]),
    .sim_done(dn[2]), .sim_pass(ps[2]), .hang_detect(hg[2]));

  // u3: hang watchdog
  sim_run_ctrl #(.HANG_CYCLES(20)) u3 (
    .clk(clk), .reset(rst), .progress_vld(pv[3]), .eot_req(eot[3]), .eot_pass(ep[3]),
    .run_state(st[3]), .cycle_count(cc[3]), .retire_total(rt[3]),
    .sim_done(dn[3]), .sim_pass(ps[3]), .hang_detect(hg[3]));

  // u4: eot, timeout and hang coincide at cycle 14
  sim_run_ctrl #(.MAX_CYCLES(15), .HANG_CYCLES(10), .DRAIN_CYCLES(4), .NUM_SRC(4)) u4 (
    .clk(clk), .reset(rst), .progress_vld(pv4), .eot_req(eot[4]), .eot_pass(ep[4]),
    .run_state(st[4]), .cycle_count(cc[4]), .retire_total(rt[4]),
    .sim_done(dn[4]), .sim_pass(ps[4]), .hang_detect(hg[4]));

  // u5: narrow counters saturate
  sim_run_ctrl #(.CYCLE_W(4)) u5 (
    .clk(clk), .reset(rst), .progress_vld(pv[5]), .eot_req(eot[5]), .eot_pass(ep[5]),
    .run_state(st[5]), .cycle_count(cc5), .retire_total(rt5),
    .sim_done(dn[5]), .sim_pass(ps[5]), .hang_detect(hg[5]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves every instance in RUN with cycle_count 0.
  task automatic do_reset();
    rst = 1'b1;
    pv[1] = 2'b11; pv[2] = 2'b01; pv[3] = 2'b01; pv[5] = 2'b11; pv4 = 4'b1011;
    for (int i = 1; i <= 5; i++) begin
      eot[i] = 1'b0;
      ep[i]  = 1'b0;
    end
    pv[4] = 2'b00;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_state"}, 32'(st[1]), 32'(IDLE));
    chk({tag, "_cc"},    cc[1], 32'd0);
    chk({tag, "_rt"},    rt[1], 32'd0);
    chk({tag, "_done"},  32'(dn[1]), 32'd0);
    chk({tag, "_pass"},  32'(ps[1]), 32'd0);
    chk({tag, "_hang"},  32'(hg[1]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    // Reset state and first edge after release
    rst = 1'b1;
    pv[1] = 2'b11; pv[2] = 2'b01; pv[3] = 2'b01; pv[4] = 2'b00; pv[5] = 2'b11; pv4 = 4'b1011;
    for (int i = 1; i <= 5; i++) begin
      eot[i] = 1'b0;
      ep[i]  = 1'b0;
    end
    step(2);
    chk_cleared("rst");
    rst = 1'b0;
    #1;
    chk("rel_idle", 32'(st[1]), 32'(IDLE));
    step(1);
    chk("rel_run", 32'(st[1]), 32'(RUN));
    chk("rel_cc", cc[1], 32'd0);

    // 1: eot with pass at cycle 50, 16-cycle drain
    do_reset();
    step(50);
    chk("t1_cc50", cc[1], 32'd50);
    chk("t1_rt50", rt[1], 32'd100);
    eot[1] = 1'b1; ep[1] = 1'b1;
    step(1);
    eot[1] = 1'b0; ep[1] = 1'b0;
    chk("t1_drain", 32'(st[1]), 32'(DRAIN));
    chk("t1_cc51", cc[1], 32'd51);
    chk("t1_nodone", 32'(dn[1]), 32'd0);
    step(15);
    chk("t1_drain66", 32'(st[1]), 32'(DRAIN));
    chk("t1_cc66", cc[1], 32'd66);
    step(1);
    chk("t1_done", 32'(st[1]), 32'(DONE));
    chk("t1_cc67", cc[1], 32'd67);
    chk("t1_rt", rt[1], 32'd134);
    chk("t1_sim_done", 32'(dn[1]), 32'd1);
    chk("t1_sim_pass", 32'(ps[1]), 32'd1);
    chk("t1_hang", 32'(hg[1]), 32'd0);
    step(5);
    chk("t1_cc_frz", cc[1], 32'd67);
    chk("t1_rt_frz", rt[1], 32'd134);

    // 2: timeout at MAX_CYCLES=100
    do_reset();
    step(99);
    chk("t2_run99", 32'(st[2]), 32'(RUN));
    chk("t2_cc99", cc[2], 32'd99);
    step(1);
    chk("t2_done", 32'(st[2]), 32'(DONE));
    chk("t2_cc100", cc[2], 32'd100);
    chk("t2_sim_done", 32'(dn[2]), 32'd1);
    chk("t2_sim_pass", 32'(ps[2]), 32'd0);
    step(5);
    chk("t2_cc_frz", cc[2], 32'd100);
    chk("t2_hang", 32'(hg[2]), 32'd0);

    // 3: progress stops after 10 cycles, HANG_CYCLES=20
    do_reset();
    step(10);
    pv[3] = 2'b00;
    chk("t3_rt", rt[3], 32'd10);
    step(19);
    chk("t3_run29", 32'(st[3]), 32'(RUN));
    chk("t3_cc29", cc[3], 32'd29);
    step(1);
    chk("t3_hang_st", 32'(st[3]), 32'(HANG));
    chk("t3_hang", 32'(hg[3]), 32'd1);
    chk("t3_done", 32'(dn[3]), 32'd1);
    chk("t3_pass", 32'(ps[3]), 32'd0);
    chk("t3_cc30", cc[3], 32'd30);
    eot[3] = 1'b1; ep[3] = 1'b1;
    step(3);
    eot[3] = 1'b0; ep[3] = 1'b0;
    chk("t3_late_st", 32'(st[3]), 32'(HANG));
    chk("t3_late_pass", 32'(ps[3]), 32'd0);
    chk("t3_late_cc", cc[3], 32'd30);

    // 4: eot beats coincident timeout and hang; 4'b1011 x5 retires 15
    do_reset();
    step(5);
    chk("t4_rt15", rt[4], 32'd15);
    pv4 = 4'b0000;
    step(9);
    chk("t4_run14", 32'(st[4]), 32'(RUN));
    chk("t4_cc14", cc[4], 32'd14);
    eot[4] = 1'b1; ep[4] = 1'b1;
    step(1);
    eot[4] = 1'b0; ep[4] = 1'b0;
    chk("t4_drain", 32'(st[4]), 32'(DRAIN));
    chk("t4_cc15", cc[4], 32'd15);
    chk("t4_rt_drain", rt[4], 32'd15);
    step(4);
    chk("t4_done", 32'(st[4]), 32'(DONE));
    chk("t4_pass", 32'(ps[4]), 32'd1);
    chk("t4_nohang", 32'(hg[4]), 32'd0);

    // 5: 4-bit counters saturate, no spurious timeout
    do_reset();
    step(7);
    chk("t5_rt14", 32'(rt5), 32'd14);
    chk("t5_cc7", 32'(cc5), 32'd7);
    step(1);
    chk("t5_rt_sat", 32'(rt5), 32'd15);
    step(6);
    chk("t5_cc14", 32'(cc5), 32'd14);
    step(1);
    chk("t5_cc15", 32'(cc5), 32'd15);
    step(5);
    chk("t5_cc_sat", 32'(cc5), 32'd15);
    chk("t5_rt_hold", 32'(rt5), 32'd15);
    chk("t5_run", 32'(st[5]), 32'(RUN));

    // 6: async reset in DRAIN and in DONE
    do_reset();
    step(3);
    eot[1] = 1'b1; ep[1] = 1'b1;
    step(1);
    eot[1] = 1'b0; ep[1] = 1'b0;
    step(3);
    chk("t6_in_drain", 32'(st[1]), 32'(DRAIN));
    rst = 1'b1;
    #1;
    chk_cleared("t6_drn");
    step(1);
    rst = 1'b0;
    #1;
    chk("t6_rel_idle", 32'(st[1]), 32'(IDLE));
    step(1);
    chk("t6_rel_run", 32'(st[1]), 32'(RUN));
    chk("t6_rel_cc", cc[1], 32'd0);
    eot[1] = 1'b1; ep[1] = 1'b0;
    step(1);
    eot[1] = 1'b0;
    step(16);
    chk("t6_done", 32'(st[1]), 32'(DONE));
    chk("t6_fail_done", 32'(dn[1]), 32'd1);
    chk("t6_fail_pass", 32'(ps[1]), 32'd0);
    rst = 1'b1;
    #1;
    chk_cleared("t6_dne");
    step(1);
    rst = 1'b0;
    step(1);
    chk("t6_rel2_run", 32'(st[1]), 32'(RUN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
